// File: rtl/arf_write_buffer.sv
// arf_write_buffer: in-order two-wide commit write buffer feeding the register RAM,
// with same-address conflict resolution on drain and a youngest-match forwarding lookup.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
module arf_write_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = `DATA_LEN,
    parameter int DEPTH  = 8,
    parameter bit CHK_EN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enq_valid1_i,
    input  logic [ADDR_W-1:0]        enq_addr1_i,
    input  logic [DATA_W-1:0]        enq_data1_i,
    input  logic                     enq_valid2_i,
    input  logic [ADDR_W-1:0]        enq_addr2_i,
    input  logic [DATA_W-1:0]        enq_data2_i,
    output logic                     enq_ready_o,
    input  logic                     drain_en_i,
    output logic [ADDR_W-1:0]        waddr1_o,
    output logic [DATA_W-1:0]        wdata1_o,
    output logic                     we1_o,
    output logic [ADDR_W-1:0]        waddr2_o,
    output logic [DATA_W-1:0]        wdata2_o,
    output logic                     we2_o,
    input  logic [ADDR_W-1:0]        lkup_addr_i,
    output logic                     lkup_hit_o,
    output logic [DATA_W-1:0]        lkup_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_ready, w_e1, w_e2, w_one, w_two, w_conflict;
    logic [PTR_W-1:0]  w_head1, w_tail2;
    logic [1:0]        w_n_enq, w_n_pop;
    logic [DEPTH-1:0]  w_set, w_clr;

    assign w_ready    = r_count <= CNT_W'(DEPTH - 2);
    assign w_e1       = w_ready & enq_valid1_i & (enq_addr1_i != '0);
    assign w_e2       = w_ready & enq_valid2_i & (enq_addr2_i != '0);
    assign w_n_enq    = {1'b0, w_e1} + {1'b0, w_e2};
    assign w_one      = r_count != '0;
    assign w_two      = r_count >= CNT_W'(2);
    assign w_head1    = r_head + PTR_W'(1);
    // slot 2 lands right behind slot 1, or at the tail itself when slot 1 was dropped
    assign w_tail2    = r_tail + PTR_W'(w_e1);
    assign w_conflict = w_two & (r_addr[r_head] == r_addr[w_head1]);
    assign w_n_pop    = drain_en_i ? (w_two ? 2'd2 : {1'b0, w_one}) : 2'd0;

    assign waddr1_o    = w_one ? r_addr[r_head]  : '0;
    assign wdata1_o    = w_one ? r_data[r_head]  : '0;
    assign waddr2_o    = w_two ? r_addr[w_head1] : '0;
    assign wdata2_o    = w_two ? r_data[w_head1] : '0;
    assign we1_o       = drain_en_i & w_one & ~w_conflict;
    assign we2_o       = drain_en_i & w_two;
    assign enq_ready_o = w_ready;
    assign count_o     = r_count;
    assign empty_o     = r_count == '0;
    assign full_o      = r_count == CNT_W'(DEPTH);

    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (w_n_pop != 2'd0) w_clr[r_head] = 1'b1;
        if (w_n_pop == 2'd2) w_clr[w_head1] = 1'b1;
        if (w_e1) w_set[r_tail] = 1'b1;
        if (w_e2) w_set[w_tail2] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_pop);
            r_tail  <= r_tail + PTR_W'(w_n_enq);
            r_count <= r_count + CNT_W'(w_n_enq) - CNT_W'(w_n_pop);
            r_valid <= (r_valid & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_e1) begin
            r_addr[r_tail] <= enq_addr1_i;
            r_data[r_tail] <= enq_data1_i;
        end
        if (w_e2) begin
            r_addr[w_tail2] <= enq_addr2_i;
            r_data[w_tail2] <= enq_data2_i;
        end
    end

    // walk oldest to youngest so the last match is the youngest pending value
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        lkup_hit_o  = 1'b0;
        lkup_data_o = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_valid[w_idx] && lkup_addr_i != '0 && r_addr[w_idx] == lkup_addr_i) begin
                lkup_hit_o  = 1'b1;
                lkup_data_o = r_data[w_idx];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (CHK_EN && rst_ni && !w_ready)
            assert (!(enq_valid1_i || enq_valid2_i)) else $error("enqueue while enq_ready_o=0");
    end
`endif
endmodule

// File: tb/tb_arf_write_buffer.sv
// tb_arf_write_buffer: directed table, corner sequences and random traffic checked
// against a queue-based model of the buffer and the RAM it writes.
module tb_arf_write_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enq_valid1_i, enq_valid2_i, drain_en_i;
    logic [4:0]  enq_addr1_i, enq_addr2_i, lkup_addr_i;
    logic [31:0] enq_data1_i, enq_data2_i;
    logic        enq_ready_o, we1_o, we2_o, lkup_hit_o, empty_o, full_o;
    logic [4:0]  waddr1_o, waddr2_o;
    logic [31:0] wdata1_o, wdata2_o, lkup_data_o;
    logic [3:0]  count_o;

    arf_write_buffer #(.ADDR_W(5), .DATA_W(32), .DEPTH(8), .CHK_EN(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .enq_valid1_i(enq_valid1_i), .enq_addr1_i(enq_addr1_i), .enq_data1_i(enq_data1_i),
        .enq_valid2_i(enq_valid2_i), .enq_addr2_i(enq_addr2_i), .enq_data2_i(enq_data2_i),
        .enq_ready_o(enq_ready_o), .drain_en_i(drain_en_i),
        .waddr1_o(waddr1_o), .wdata1_o(wdata1_o), .we1_o(we1_o),
        .waddr2_o(waddr2_o), .wdata2_o(wdata2_o), .we2_o(we2_o),
        .lkup_addr_i(lkup_addr_i), .lkup_hit_o(lkup_hit_o), .lkup_data_o(lkup_data_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int a; int d; } ent_t;
    typedef struct {
        int v1, a1, d1, v2, a2, d2, den, la;
        int c, we1, we2, wa1, wd1, wa2, wd2, hit, ld;
    } vec_t;

    ent_t q[$];
    int   ref_ram[32];
    int   dut_ram[32];
    int   total = 0;
    int   bad = 0;
    vec_t tbl[11];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(int v1, int a1, int d1, int v2, int a2, int d2, int den, int la);
        enq_valid1_i = v1[0];
        enq_addr1_i  = 5'(a1);
        enq_data1_i  = 32'(d1);
        enq_valid2_i = v2[0];
        enq_addr2_i  = 5'(a2);
        enq_data2_i  = 32'(d2);
        drain_en_i   = den[0];
        lkup_addr_i  = 5'(la);
    endtask

    // expected outputs derived from the pending-write queue
    task automatic model_check();
        int n = q.size();
        logic hit = 1'b0;
        logic [31:0] ld = '0;
        logic conf;
        conf = n >= 2 && q[0].a == q[1].a;
        for (int i = 0; i < n; i++)
            if (lkup_addr_i != 0 && q[i].a == int'(lkup_addr_i)) begin
                hit = 1'b1;
                ld  = q[i].d;
            end
        chk("count", 32'(count_o), n);
        chk("ready", 32'(enq_ready_o), 32'(8 - n >= 2));
        chk("empty", 32'(empty_o), 32'(n == 0));
        chk("full", 32'(full_o), 32'(n == 8));
        chk("we1", 32'(we1_o), 32'(drain_en_i && n >= 1 && !conf));
        chk("we2", 32'(we2_o), 32'(drain_en_i && n >= 2));
        chk("waddr1", 32'(waddr1_o), n >= 1 ? q[0].a : 0);
        chk("wdata1", wdata1_o, n >= 1 ? q[0].d : 0);
        chk("waddr2", 32'(waddr2_o), n >= 2 ? q[1].a : 0);
        chk("wdata2", wdata2_o, n >= 2 ? q[1].d : 0);
        chk("lkup_hit", 32'(lkup_hit_o), 32'(hit));
        chk("lkup_data", lkup_data_o, ld);
    endtask

    task automatic tick();
        logic s1 = we1_o, s2 = we2_o;
        int sa1 = int'(waddr1_o), sa2 = int'(waddr2_o);
        int sd1 = int'(wdata1_o), sd2 = int'(wdata2_o);
        bit rdy = q.size() <= 6;
        @(posedge clk_i);
        if (s1) dut_ram[sa1] = sd1;
        if (s2) dut_ram[sa2] = sd2;
        if (drain_en_i)
            for (int k = 0; k < 2; k++)
                if (q.size() > 0) begin
                    ent_t e = q.pop_front();
                    ref_ram[e.a] = e.d;
                end
        if (rdy) begin
            if (enq_valid1_i && enq_addr1_i != 0) q.push_back('{int'(enq_addr1_i), int'(enq_data1_i)});
            if (enq_valid2_i && enq_addr2_i != 0) q.push_back('{int'(enq_addr2_i), int'(enq_data2_i)});
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_ram[i] = 0;
            dut_ram[i] = 0;
        end
        //          v1 a1 d1    v2 a2 d2    den la  c we1 we2 wa1 wd1  wa2 wd2  hit ld
        tbl[0]  = '{0, 0, 0,    0, 0, 0,    0,  0,  0, 0, 0,  0,  0,    0,  0,    0,  0};
        tbl[1]  = '{1, 3, 'h11, 1, 4, 'h22, 0,  3,  0, 0, 0,  0,  0,    0,  0,    0,  0};
        tbl[2]  = '{0, 0, 0,    0, 0, 0,    1,  4,  2, 1, 1,  3,  'h11, 4,  'h22, 1,  'h22};
        tbl[3]  = '{1, 5, 'hA,  1, 5, 'hB,  0,  3,  0, 0, 0,  0,  0,    0,  0,    0,  0};
        tbl[4]  = '{0, 0, 0,    0, 0, 0,    0,  5,  2, 0, 0,  5,  'hA,  5,  'hB,  1,  'hB};
        tbl[5]  = '{0, 0, 0,    0, 0, 0,    1,  5,  2, 0, 1,  5,  'hA,  5,  'hB,  1,  'hB};
        tbl[6]  = '{1, 0, 'h55, 1, 7, 'h77, 0,  0,  0, 0, 0,  0,  0,    0,  0,    0,  0};
        tbl[7]  = '{0, 0, 0,    0, 0, 0,    0,  0,  1, 0, 0,  7,  'h77, 0,  0,    0,  0};
        tbl[8]  = '{0, 0, 0,    0, 0, 0,    0,  7,  1, 0, 0,  7,  'h77, 0,  0,    1,  'h77};
        tbl[9]  = '{0, 0, 0,    0, 0, 0,    1,  7,  1, 1, 0,  7,  'h77, 0,  0,    1,  'h77};
        tbl[10] = '{0, 0, 0,    0, 0, 0,    0,  7,  0, 0, 0,  0,  0,    0,  0,    0,  0};

        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 3);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_ready", 32'(enq_ready_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_we", {30'd0, we1_o, we2_o}, 0);
        chk("rst_hit", 32'(lkup_hit_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_waddr1", 32'(waddr1_o), 0);
        rst_ni = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].v2, tbl[i].a2, tbl[i].d2, tbl[i].den, tbl[i].la);
            #4;
            chk($sformatf("t%0d_count", i), 32'(count_o), tbl[i].c);
            chk($sformatf("t%0d_we", i), {30'd0, we1_o, we2_o}, {30'd0, tbl[i].we1[0], tbl[i].we2[0]});
            chk($sformatf("t%0d_waddr1", i), 32'(waddr1_o), tbl[i].wa1);
            chk($sformatf("t%0d_wdata1", i), wdata1_o, tbl[i].wd1);
            chk($sformatf("t%0d_waddr2", i), 32'(waddr2_o), tbl[i].wa2);
            chk($sformatf("t%0d_wdata2", i), wdata2_o, tbl[i].wd2);
            chk($sformatf("t%0d_hit", i), 32'(lkup_hit_o), tbl[i].hit);
            chk($sformatf("t%0d_ldata", i), lkup_data_o, tbl[i].ld);
            model_check();
            tick();
        end

        for (int p = 0; p < 4; p++) begin
            set_in(1, 8 + 2 * p, 'h100 + p, 1, 9 + 2 * p, 'h200 + p, 0, 9);
            #4;
            model_check();
            tick();
            if (p == 2) begin
                chk("fill3_count", 32'(count_o), 6);
                chk("fill3_ready", 32'(enq_ready_o), 1);
            end
        end
        chk("fill4_count", 32'(count_o), 8);
        chk("fill4_full", 32'(full_o), 1);
        chk("fill4_ready", 32'(enq_ready_o), 0);
        set_in(1, 20, 'hDEAD, 1, 21, 'hBEEF, 0, 20);
        #4;
        model_check();
        tick();
        chk("ovf_count", 32'(count_o), 8);
        chk("ovf_hit", 32'(lkup_hit_o), 0);
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 9 + 2 * c);
            #4;
            model_check();
            tick();
        end
        chk("drained_empty", 32'(empty_o), 1);

        for (int c = 0; c < 20; c++) begin
            set_in(1, $urandom_range(1, 7), $urandom, 1, $urandom_range(1, 7), $urandom, 1, $urandom_range(0, 7));
            #4;
            model_check();
            tick();
        end
        for (int c = 0; c < 60; c++) begin
            bit r = q.size() <= 6;
            set_in(r && ($urandom % 4 != 0), $urandom_range(0, 7), $urandom,
                   r && ($urandom % 3 != 0), $urandom_range(0, 7), $urandom,
                   $urandom % 3 != 0, $urandom_range(0, 7));
            #4;
            model_check();
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0);
            #4;
            model_check();
            tick();
        end
        for (int i = 0; i < 32; i++) chk($sformatf("ram_x%0d", i), dut_ram[i], ref_ram[i]);

        set_in(1, 12, 'h1234, 1, 13, 'h5678, 0, 12);
        #4;
        model_check();
        tick();
        rst_ni = 1'b0;
        drain_en_i = 1'b1;
        #2;
        chk("mrst_count", 32'(count_o), 0);
        chk("mrst_we", {30'd0, we1_o, we2_o}, 0);
        chk("mrst_hit", 32'(lkup_hit_o), 0);
        chk("mrst_empty", 32'(empty_o), 1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        q.delete();
        set_in(0, 0, 0, 0, 0, 0, 1, 13);
        #4;
        model_check();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arf_write_buffer.md
Name: arf_write_buffer

Overview:
- Write-side client for the dispatch-stage 4-read/2-write register RAM.
- Accepts up to two committed register writes per cycle from retirement and buffers them in order in a circular FIFO.
- Drains up to two writes per cycle onto the RAM's two write ports.
- Resolves same-address conflicts and exposes a forwarding lookup, so readers can see values that are pending but not yet in the RAM.

Parameters:
- ADDR_W, 5: register address width; matches the RAM address width.
- DATA_W, `DATA_LEN: register data width.
- DEPTH, 8: FIFO entries; power of two, at least 4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enq_valid1_i  in  1  commit write 1 valid (older)
- enq_addr1_i  in  ADDR_W  commit write 1 address
- enq_data1_i  in  DATA_W  commit write 1 data
- enq_valid2_i  in  1  commit write 2 valid (younger)
- enq_addr2_i  in  ADDR_W  commit write 2 address
- enq_data2_i  in  DATA_W  commit write 2 data
- enq_ready_o  out  1  at least 2 free entries
- drain_en_i  in  1  permit RAM writes this cycle
- waddr1_o  out  ADDR_W  RAM write port 1 address
- wdata1_o  out  DATA_W  RAM write port 1 data
- we1_o  out  1  RAM write port 1 enable
- waddr2_o  out  ADDR_W  RAM write port 2 address
- wdata2_o  out  DATA_W  RAM write port 2 data
- we2_o  out  1  RAM write port 2 enable
- lkup_addr_i  in  ADDR_W  forwarding lookup address
- lkup_hit_o  out  1  lookup address pending in buffer
- lkup_data_o  out  DATA_W  youngest pending data for lookup address
- count_o  out  $clog2(DEPTH)+1  occupied entries
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Head pointer, tail pointer and count all go to 0.
  - All entry valid bits are cleared.
  - Output values during reset: we1_o=0, we2_o=0, lkup_hit_o=0, empty_o=1, full_o=0, enq_ready_o=1.
  - Address and data outputs are 0 while the buffer is empty.
  - Reset asserted mid-operation discards all pending writes.
- Enqueue, sampled at the clock edge:
  - enq_ready_o = (DEPTH - count_o >= 2). It is computed from registered count only; same-cycle drains are not credited.
  - When enq_ready_o=1, each valid slot whose address is nonzero is written at the tail. Slot 1 is written before slot 2.
  - Writes to address 0 are dropped and consume no entry.
  - If only slot 2 is valid, it takes a single entry; entries stay compacted.
  - When enq_ready_o=0, enqueue inputs are ignored. A valid enqueue in that case is a protocol violation, caught by a simulation assertion.
- Drain outputs:
  - Combinational from registered head entries only. There is no combinational path from any enq_* input to any w*_o output.
  - Port 1 carries the entry at head; port 2 carries the entry at head+1.
  - If count >= 2 and drain_en_i=1: we1_o=1, we2_o=1, and both entries pop at the edge.
  - If count == 1 and drain_en_i=1: we1_o=1, we2_o=0, and one entry pops.
  - If drain_en_i=0 or the buffer is empty: both enables are 0 and nothing pops.
  - Conflict rule: if both drained entries have the same address, we1_o=0 and we2_o=1 (younger wins). Both entries still pop.
- Latency: an entry enqueued at edge N appears on the write ports after edge N and is written into the RAM at edge N+1, provided drain_en_i=1.
- Simultaneous enqueue and drain:
  - count_next = count + enqueued - drained.
  - Pointers wrap modulo DEPTH.
  - count never exceeds DEPTH.
- Lookup (combinational):
  - lkup_hit_o=1 when lkup_addr_i is nonzero and matches any valid buffered entry.
  - lkup_data_o is the data of the youngest matching entry (nearest to tail), else 0.
  - Entries being enqueued in the current cycle are not visible.
  - Entries draining in the current cycle remain visible until the edge.

Test Plan:
- Reset then idle -> empty_o=1, enq_ready_o=1, we1_o=0, we2_o=0, count_o=0.
- Enqueue (x3=0x11, x4=0x22) with drain_en_i=0; next cycle assert drain_en_i -> waddr1_o=3, wdata1_o=0x11, waddr2_o=4, wdata2_o=0x22, both enables 1; count_o goes 2 -> 0.
- Enqueue (x5=0xA, x5=0xB), drain -> we1_o=0, we2_o=1, wdata2_o=0xB; meanwhile lookup x5 before the drain -> hit, data 0xB.
- Enqueue (x0=0x55, x7=0x77) -> count_o=1, head address 7; lookup x0 -> no hit.
- drain_en_i=0; fill with 3 pairs into DEPTH=8 -> count_o=6, enq_ready_o=1; 4th pair -> count_o=8, full_o=1, enq_ready_o=0; further enqueue -> count_o unchanged.
- Continuous pairwise enqueue plus drain for 20 cycles -> pointers wrap, RAM contents equal the in-order reference model; assert rst_ni mid-stream -> count_o=0 and no enables asserted.
